// File: rtl/mem_stage_if.sv
// Bundle between the EX/MEM pipeline side (plus data memory) and the memory-stage sequencer.
interface mem_stage_if #(
    parameter int AW = 16
);
    logic          valid_in;
    logic [2:0]    op;
    logic [AW-1:0] addr_in;
    logic [15:0]   wdata_in;
    logic [31:0]   wdata32_in;
    logic [15:0]   mem_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          stall;
    logic          done;
    logic [31:0]   rdata_out;
    logic [AW-1:0] sp_out;
    logic          exc;
    logic [1:0]    exc_code;

    // Pipeline and memory side: issues operations, returns read data.
    modport master (
        output valid_in, op, addr_in, wdata_in, wdata32_in, mem_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, stall, done,
        input  rdata_out, sp_out, exc, exc_code
    );

    // Sequencer side.
    modport slave (
        input  valid_in, op, addr_in, wdata_in, wdata32_in, mem_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, stall, done,
        output rdata_out, sp_out, exc, exc_code
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: turns EX/MEM ops into word-wide memory strobes, owns the
// stack pointer, splits 32-bit push/pop into two accesses and flags illegal accesses.
module mem_stage_ctrl #(
    parameter int            AW      = 16,
    parameter logic [AW-1:0] MEM_TOP = 16'h07FF
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_stage_if.slave bus
);
    localparam logic [2:0] OP_LDD    = 3'd1;
    localparam logic [2:0] OP_STD    = 3'd2;
    localparam logic [2:0] OP_PUSH   = 3'd3;
    localparam logic [2:0] OP_POP    = 3'd4;
    localparam logic [2:0] OP_PUSH32 = 3'd5;
    localparam logic [2:0] OP_POP32  = 3'd6;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ADDR  = 2'b01;
    localparam logic [1:0] EXC_OVF   = 2'b10;
    localparam logic [1:0] EXC_UNF   = 2'b11;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t        state;
    logic [AW-1:0] sp;
    logic          pop32_p1;     // second half belongs to a POP32 (else PUSH32)
    logic [15:0]   lo_word_p1;   // low half carried into SECOND (push data or popped word)
    logic          done_q;
    logic          exc_q;
    logic [1:0]    code_q;
    logic [31:0]   rdata_q;

    logic [AW-1:0] sp_inc1, sp_inc2, sp_dec1, sp_dec2;
    logic          op_act;
    logic          start32;
    logic [1:0]    code_c;
    logic          rd_c, wr_c, stall_c;
    logic [AW-1:0] addr_c;
    logic [15:0]   wdata_c;

    // 16-bit wrap is intentional: POP at SP=FFFF targets address 0.
    assign sp_inc1 = sp + AW'(1);
    assign sp_inc2 = sp + AW'(2);
    assign sp_dec1 = sp - AW'(1);
    assign sp_dec2 = sp - AW'(2);

    // Reserved op 7 behaves like NOP.
    assign op_act  = (state == IDLE) && bus.valid_in &&
                     (bus.op != 3'd0) && (bus.op != 3'd7);
    assign start32 = op_act && (code_c == EXC_NONE) &&
                     ((bus.op == OP_PUSH32) || (bus.op == OP_POP32));

    // Legality checks and memory strobes; memory samples these on the falling edge.
    always_comb begin
        code_c  = EXC_NONE;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        stall_c = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        if (state == SECOND) begin
            if (pop32_p1) begin
                rd_c   = 1'b1;
                addr_c = sp_inc2;
            end else begin
                wr_c    = 1'b1;
                addr_c  = sp_dec1;
                wdata_c = lo_word_p1;
            end
        end else if (bus.valid_in) begin
            case (bus.op)
                OP_LDD: begin
                    if (bus.addr_in > MEM_TOP) code_c = EXC_ADDR;
                    else begin
                        rd_c   = 1'b1;
                        addr_c = bus.addr_in;
                    end
                end
                OP_STD: begin
                    if (bus.addr_in > MEM_TOP) code_c = EXC_ADDR;
                    else begin
                        wr_c    = 1'b1;
                        addr_c  = bus.addr_in;
                        wdata_c = bus.wdata_in;
                    end
                end
                OP_PUSH: begin
                    if (sp > MEM_TOP) code_c = EXC_OVF;
                    else begin
                        wr_c    = 1'b1;
                        addr_c  = sp;
                        wdata_c = bus.wdata_in;
                    end
                end
                OP_POP: begin
                    if (sp_inc1 > MEM_TOP) code_c = EXC_UNF;
                    else begin
                        rd_c   = 1'b1;
                        addr_c = sp_inc1;
                    end
                end
                OP_PUSH32: begin
                    if ((sp > MEM_TOP) || (sp == '0)) code_c = EXC_OVF;
                    else begin
                        wr_c    = 1'b1;
                        addr_c  = sp;
                        wdata_c = bus.wdata32_in[31:16];
                        stall_c = 1'b1;
                    end
                end
                OP_POP32: begin
                    if (sp_inc2 > MEM_TOP) code_c = EXC_UNF;
                    else begin
                        rd_c    = 1'b1;
                        addr_c  = sp_inc1;
                        stall_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, stack pointer and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sp       <= MEM_TOP;
            pop32_p1 <= 1'b0;
            done_q   <= 1'b0;
            exc_q    <= 1'b0;
            code_q   <= EXC_NONE;
            rdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            exc_q  <= 1'b0;
            code_q <= EXC_NONE;
            case (state)
                IDLE: begin
                    if (op_act) begin
                        if (code_c != EXC_NONE) begin
                            done_q <= 1'b1;
                            exc_q  <= 1'b1;
                            code_q <= code_c;
                        end else begin
                            case (bus.op)
                                OP_LDD: begin
                                    done_q  <= 1'b1;
                                    rdata_q <= {16'h0000, bus.mem_rdata};
                                end
                                OP_STD: done_q <= 1'b1;
                                OP_PUSH: begin
                                    done_q <= 1'b1;
                                    sp     <= sp_dec1;
                                end
                                OP_POP: begin
                                    done_q  <= 1'b1;
                                    rdata_q <= {16'h0000, bus.mem_rdata};
                                    sp      <= sp_inc1;
                                end
                                OP_PUSH32, OP_POP32: begin
                                    state    <= SECOND;
                                    pop32_p1 <= (bus.op == OP_POP32);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                SECOND: begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                    if (pop32_p1) begin
                        sp      <= sp_inc2;
                        rdata_q <= {bus.mem_rdata, lo_word_p1};
                    end else begin
                        sp <= sp_dec2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Low half captured on the first cycle of a 32-bit op: push data, or the popped low word.
    always_ff @(posedge clk) begin
        if (start32)
            lo_word_p1 <= (bus.op == OP_POP32) ? bus.mem_rdata : bus.wdata32_in[15:0];
    end

    assign bus.mem_read  = rd_c;
    assign bus.mem_write = wr_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.stall     = stall_c;
    assign bus.done      = done_q;
    assign bus.exc       = exc_q;
    assign bus.exc_code  = code_q;
    assign bus.rdata_out = rdata_q;
    assign bus.sp_out    = sp;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a 2K x 16 data memory plus a stack/memory reference model
// driven with directed and random operation sequences.
module tb_mem_stage_ctrl;
    localparam logic [15:0] TOP = 16'h07FF;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_stage_if bus ();

    mem_stage_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory: acts on the falling edge, as the real array does.
    logic [15:0] mem [0:2047] = '{default: 16'h0000};
    always @(negedge clk) begin
        if (bus.mem_write && bus.mem_addr <= TOP) mem[bus.mem_addr[10:0]] <= bus.mem_wdata;
        if (bus.mem_read && bus.mem_addr <= TOP) bus.mem_rdata <= mem[bus.mem_addr[10:0]];
    end

    // Reference state.
    logic [15:0] model_mem [0:2047];
    logic [15:0] sp_m;
    logic [31:0] rdata_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at posedge+1, follow it to retirement and compare everything.
    task automatic run_op(input logic v, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] wd, input logic [31:0] w32);
        int          n_cyc, n_acc;
        logic        acc_wr [2];
        logic [15:0] acc_ad [2];
        logic [15:0] acc_wd [2];
        logic        stl [2];
        logic        e_done, e_exc;
        logic [1:0]  e_code;
        logic [15:0] s1, s2;
        n_cyc = 1; n_acc = 0; e_done = 0; e_exc = 0; e_code = 0;
        stl[0] = 0; stl[1] = 0;
        acc_wr[0] = 0; acc_wr[1] = 0; acc_ad[0] = 0; acc_ad[1] = 0; acc_wd[0] = 0; acc_wd[1] = 0;
        s1 = sp_m + 16'd1;
        s2 = sp_m + 16'd2;
        if (v) begin
            case (o)
                3'd1, 3'd2: begin
                    e_done = 1;
                    if (a > TOP) begin e_exc = 1; e_code = 2'b01; end
                    else begin
                        n_acc = 1; acc_ad[0] = a;
                        if (o == 3'd1) rdata_m = {16'h0, model_mem[a[10:0]]};
                        else begin acc_wr[0] = 1; acc_wd[0] = wd; model_mem[a[10:0]] = wd; end
                    end
                end
                3'd3: begin
                    e_done = 1;
                    if (sp_m > TOP) begin e_exc = 1; e_code = 2'b10; end
                    else begin
                        n_acc = 1; acc_wr[0] = 1; acc_ad[0] = sp_m; acc_wd[0] = wd;
                        model_mem[sp_m[10:0]] = wd;
                        sp_m = sp_m - 16'd1;
                    end
                end
                3'd4: begin
                    e_done = 1;
                    if (s1 > TOP) begin e_exc = 1; e_code = 2'b11; end
                    else begin
                        n_acc = 1; acc_ad[0] = s1;
                        rdata_m = {16'h0, model_mem[s1[10:0]]};
                        sp_m = s1;
                    end
                end
                3'd5: begin
                    e_done = 1;
                    if (sp_m > TOP || sp_m == 0) begin e_exc = 1; e_code = 2'b10; end
                    else begin
                        n_cyc = 2; n_acc = 2; stl[0] = 1;
                        acc_wr[0] = 1; acc_ad[0] = sp_m;         acc_wd[0] = w32[31:16];
                        acc_wr[1] = 1; acc_ad[1] = sp_m - 16'd1; acc_wd[1] = w32[15:0];
                        model_mem[acc_ad[0][10:0]] = w32[31:16];
                        model_mem[acc_ad[1][10:0]] = w32[15:0];
                        sp_m = sp_m - 16'd2;
                    end
                end
                3'd6: begin
                    e_done = 1;
                    if (s2 > TOP) begin e_exc = 1; e_code = 2'b11; end
                    else begin
                        n_cyc = 2; n_acc = 2; stl[0] = 1;
                        acc_ad[0] = s1; acc_ad[1] = s2;
                        rdata_m = {model_mem[s2[10:0]], model_mem[s1[10:0]]};
                        sp_m = s2;
                    end
                end
                default: ;
            endcase
        end

        bus.valid_in = v; bus.op = o; bus.addr_in = a; bus.wdata_in = wd; bus.wdata32_in = w32;
        for (int c = 0; c < n_cyc; c++) begin
            #2;
            check_eq("rd_wr_exclusive", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
            check_eq("stall", {31'h0, bus.stall}, {31'h0, stl[c]});
            if (c < n_acc) begin
                check_eq("mem_write", {31'h0, bus.mem_write}, {31'h0, acc_wr[c]});
                check_eq("mem_read", {31'h0, bus.mem_read}, {31'h0, ~acc_wr[c]});
                check_eq("mem_addr", {16'h0, bus.mem_addr}, {16'h0, acc_ad[c]});
                if (acc_wr[c]) check_eq("mem_wdata", {16'h0, bus.mem_wdata}, {16'h0, acc_wd[c]});
            end else begin
                check_eq("no_access", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
            end
            @(posedge clk); #1;
            if (c == n_cyc - 1) bus.valid_in = 1'b0;
            else check_eq("done_early", {31'h0, bus.done}, 32'h0);
        end
        check_eq("done", {31'h0, bus.done}, {31'h0, e_done});
        check_eq("exc", {31'h0, bus.exc}, {31'h0, e_exc});
        check_eq("exc_code", {30'h0, bus.exc_code}, {30'h0, e_code});
        check_eq("rdata_out", bus.rdata_out, rdata_m);
        check_eq("sp_out", {16'h0, bus.sp_out}, {16'h0, sp_m});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [15:0] ra;
        for (int i = 0; i < 2048; i++) model_mem[i] = 16'h0000;
        sp_m = TOP; rdata_m = 32'h0;
        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.op = 3'd0; bus.addr_in = 16'h0;
        bus.wdata_in = 16'h0; bus.wdata32_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_done", {31'h0, bus.done}, 32'h0);
        check_eq("rst_exc", {29'h0, bus.exc, bus.exc_code}, 32'h0);
        check_eq("rst_rdata", bus.rdata_out, 32'h0);
        check_eq("rst_sp", {16'h0, bus.sp_out}, {16'h0, TOP});
        check_eq("rst_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load/store round trip.
        run_op(1, 3'd2, 16'h0010, 16'h1234, 32'h0);
        run_op(1, 3'd1, 16'h0010, 16'h0, 32'h0);
        check_eq("ldd_value", bus.rdata_out, 32'h0000_1234);

        // 16-bit stack.
        run_op(1, 3'd3, 16'h0, 16'hAAAA, 32'h0);
        run_op(1, 3'd3, 16'h0, 16'hBBBB, 32'h0);
        run_op(1, 3'd4, 16'h0, 16'h0, 32'h0);
        check_eq("pop1_value", bus.rdata_out, 32'h0000_BBBB);
        run_op(1, 3'd4, 16'h0, 16'h0, 32'h0);
        check_eq("pop2_value", bus.rdata_out, 32'h0000_AAAA);

        // 32-bit stack.
        run_op(1, 3'd5, 16'h0, 16'h0, 32'hDEAD_BEEF);
        check_eq("push32_sp", {16'h0, bus.sp_out}, 32'h0000_07FD);
        run_op(1, 3'd6, 16'h0, 16'h0, 32'h0);
        check_eq("pop32_value", bus.rdata_out, 32'hDEAD_BEEF);
        check_eq("pop32_sp", {16'h0, bus.sp_out}, 32'h0000_07FF);

        // Checks: underflow at top, bad address, POP32 underflow one below top.
        run_op(1, 3'd4, 16'h0, 16'h0, 32'h0);
        check_eq("pop_unf_code", {30'h0, bus.exc_code}, 32'h3);
        run_op(1, 3'd1, 16'h0800, 16'h0, 32'h0);
        check_eq("ldd_bad_code", {30'h0, bus.exc_code}, 32'h1);
        run_op(1, 3'd3, 16'h0, 16'h5555, 32'h0);
        run_op(1, 3'd6, 16'h0, 16'h0, 32'h0);
        check_eq("pop32_unf_sp", {16'h0, bus.sp_out}, 32'h0000_07FE);
        run_op(1, 3'd4, 16'h0, 16'h0, 32'h0);

        // Reset during the second half of PUSH32.
        bus.valid_in = 1'b1; bus.op = 3'd5; bus.wdata32_in = 32'h1357_2468;
        #2;
        check_eq("rst2_first_wr", {15'h0, bus.mem_write, bus.mem_addr}, {15'h0, 1'b1, TOP});
        model_mem[TOP[10:0]] = 16'h1357;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #2;
        check_eq("rst2_no_access", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        @(posedge clk); #1;
        check_eq("rst2_done", {31'h0, bus.done}, 32'h0);
        rst_n = 1'b1;
        rdata_m = 32'h0;
        @(posedge clk); #1;
        check_eq("rst2_done_after", {31'h0, bus.done}, 32'h0);
        check_eq("rst2_sp", {16'h0, bus.sp_out}, {16'h0, TOP});
        check_eq("rst2_mem_lo", {16'h0, mem[11'h7FE]}, {16'h0, model_mem[11'h7FE]});
        check_eq("rst2_mem_hi", {16'h0, mem[11'h7FF]}, 32'h0000_1357);
        run_op(1, 3'd3, 16'h0, 16'h7777, 32'h0);

        // Random operation mix.
        for (int i = 0; i < 400; i++) begin
            ro = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
            else ra = 16'($urandom_range(0, 2047));
            run_op($urandom_range(0, 9) != 0, ro, ra, 16'($urandom), $urandom);
        end

        // Walk SP down to 0 and exercise the wrap rules.
        for (int i = 0; i < 2100 && sp_m != 16'h0000; i++)
            run_op(1, 3'd3, 16'h0, 16'($urandom), 32'h0);
        check_eq("walk_sp_zero", {16'h0, bus.sp_out}, 32'h0);
        run_op(1, 3'd5, 16'h0, 16'h0, 32'hCAFE_F00D);
        check_eq("push32_sp0_code", {30'h0, bus.exc_code}, 32'h2);
        run_op(1, 3'd3, 16'h0, 16'h4242, 32'h0);
        check_eq("push_wrap_sp", {16'h0, bus.sp_out}, 32'h0000_FFFF);
        run_op(1, 3'd4, 16'h0, 16'h0, 32'h0);
        check_eq("pop_wrap_value", bus.rdata_out, 32'h0000_4242);
        run_op(1, 3'd3, 16'h0, 16'h9999, 32'h0);
        run_op(1, 3'd3, 16'h0, 16'h1111, 32'h0);
        check_eq("push_ovf_code", {30'h0, bus.exc_code}, 32'h2);
        run_op(1, 3'd6, 16'h0, 16'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage sequencer directly upstream of the 2K x 16 data memory (word-addressed 0x0000–0x07FF; reads and writes act on negedge clk).
- Translates EX/MEM operations into per-word memory read/write strobes, address and write data.
- Owns the stack pointer and splits 32-bit push/pop (PC save/restore) into two 16-bit accesses, stalling the pipeline for the extra cycle.
- Flags out-of-range, overflow and underflow accesses before they reach memory.

Parameters:
- MEM_TOP, 16'h07FF, highest legal word address; also the SP reset value.
- AW, 16, address and SP width.

Ports:
- clk  in  1  pipeline clock; state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  op/addr/data inputs valid this cycle.
- op  in  3  0 NOP, 1 LDD, 2 STD, 3 PUSH, 4 POP, 5 PUSH32, 6 POP32, 7 reserved (treated as NOP).
- addr_in  in  16  effective address for LDD/STD.
- wdata_in  in  16  store/push data (16-bit ops).
- wdata32_in  in  32  push data for PUSH32.
- mem_rdata  in  16  read data returned by data memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  16  memory word address.
- mem_wdata  out  16  memory write data.
- stall  out  1  hold upstream stage; inputs must stay stable.
- done  out  1  one-cycle pulse: operation retired.
- rdata_out  out  32  load/pop result ({16'h0,word} for LDD/POP).
- sp_out  out  16  current stack pointer.
- exc  out  1  one-cycle pulse with done: operation aborted.
- exc_code  out  2  01 bad address, 10 stack overflow, 11 stack underflow.

Behaviour:
- Reset (async, rst_n=0): state IDLE, SP=MEM_TOP, done=0, exc=0, exc_code=0, rdata_out=0. Memory strobes are combinationally 0 in IDLE with valid_in=0.
- Reset mid-operation: SECOND abandoned; the second word is never accessed and no done pulse is produced.
- States: IDLE, SECOND.
- Memory strobes/addr/wdata are combinational from state and inputs, so memory acts at negedge of the same cycle. Results are registered at the next posedge.
- 16-bit ops: latency 1. Op in cycle T gives done and rdata_out in T+1. stall stays 0.
- LDD: read addr_in. STD: write wdata_in to addr_in.
- PUSH: write wdata_in at SP; SP <= SP-1.
- POP: read at SP+1; SP <= SP+1.
- PUSH32 in IDLE, cycle T:
  - Write wdata32_in[31:16] at SP; stall=1.
  - Go to SECOND.
  - SECOND (T+1): write [15:0] at SP-1; stall=0; SP <= SP-2.
  - done in T+2.
- POP32:
  - T: read low word at SP+1, register it.
  - T+1 (SECOND): read high word at SP+2; SP <= SP+2.
  - rdata_out={high,low}, done in T+2.
- SP update timing: SP changes only at the posedge ending the final access. The SP used in SECOND is the pre-op value held.
- Checks, evaluated in IDLE before any access:
  - LDD/STD with addr_in>MEM_TOP: code 01.
  - PUSH with SP>MEM_TOP: code 10.
  - PUSH32 with SP>MEM_TOP or SP==0: code 10.
  - POP with SP+1>MEM_TOP (16-bit compare, no wrap): code 11.
  - POP32 with SP+2>MEM_TOP: code 11.
- On any failed check:
  - mem_read=mem_write=0, stall=0, SP unchanged, no SECOND.
  - exc=1 with done=1 next cycle; rdata_out holds its previous value.
- Wrap: PUSH at SP=0 is legal and leaves SP=16'hFFFF; the next push then overflows (code 10). POP at SP=16'hFFFF reads address 0 and is legal.
- valid_in=0 or NOP in IDLE: no access, done=0.
- Inputs are ignored in SECOND.
- Never assert mem_read and mem_write together.

Test Plan:
- Reset, then STD 0x1234→0x0010; LDD 0x0010 -> mem_write at T, done at T+1, rdata_out=0x00001234, SP=0x07FF.
- PUSH 0xAAAA, PUSH 0xBBBB, POP, POP -> writes at 0x07FF, 0x07FE; pops return 0xBBBB then 0xAAAA; SP back to 0x07FF; stall never high.
- PUSH32 0xDEADBEEF then POP32 -> writes 0xDEAD@0x07FF, 0xBEEF@0x07FE; stall=1 exactly one cycle each; done at T+2; rdata_out=0xDEADBEEF; SP=0x07FF.
- POP at reset SP -> exc=1, exc_code=11, no strobes. LDD addr 0x0800 -> exc_code=01. PUSH32 with SP=0 -> exc_code=10, SP unchanged.
- Underflow path: POP32 with SP=0x07FE -> exc_code=11, SP stays 0x07FE.
- rst_n low during SECOND of PUSH32 -> no second write, no done, SP=0x07FF, state IDLE after release.
